// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for an active-low 8-digit seven-segment display, fed by six BCD clock digits.
// Optional blinking hh.mm.ss separators on dp when SEVSEG_DP_SEPARATOR_EN is defined.
module seven_seg_scan #(
  parameter int CLK_HZ      = 100000000,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       blank,
  input  logic [5:0] hrstens,
  input  logic [5:0] hrsones,
  input  logic [5:0] mintens,
  input  logic [5:0] minones,
  input  logic [5:0] sectens,
  input  logic [5:0] secones,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RCNT_TC = RW'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("seven_seg_scan: REFRESH_DIV must be >= 2");
  end
  if (CLK_HZ < 2) begin : g_bad_clk_hz
    $error("seven_seg_scan: CLK_HZ must be >= 2");
  end

  logic [RW-1:0] rcnt;
  logic [2:0]    idx;
  logic [5:0]    sh_hrstens, sh_hrsones, sh_mintens, sh_minones, sh_sectens, sh_secones;
  logic          rcnt_tc;
  logic          frame_wrap;
  logic [5:0]    cur_digit;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign rcnt_tc    = (rcnt == RCNT_TC);
  assign frame_wrap = rcnt_tc && (idx == 3'd5);

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt       <= '0;
      idx        <= 3'd0;
      sh_hrstens <= '0;
      sh_hrsones <= '0;
      sh_mintens <= '0;
      sh_minones <= '0;
      sh_sectens <= '0;
      sh_secones <= '0;
    end else begin
      rcnt <= rcnt_tc ? '0 : rcnt + 1'b1;
      if (rcnt_tc) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      // Snapshot once per frame so a frame never mixes two clock values
      if (frame_wrap) begin
        sh_hrstens <= hrstens;
        sh_hrsones <= hrsones;
        sh_mintens <= mintens;
        sh_minones <= minones;
        sh_sectens <= sectens;
        sh_secones <= secones;
      end
    end
  end

  always_comb begin
    cur_digit = sh_secones;
    case (idx)
      3'd0:    cur_digit = sh_secones;
      3'd1:    cur_digit = sh_sectens;
      3'd2:    cur_digit = sh_minones;
      3'd3:    cur_digit = sh_mintens;
      3'd4:    cur_digit = sh_hrsones;
      3'd5:    cur_digit = sh_hrstens;
      default: cur_digit = sh_secones;
    endcase
  end

  // Segment order {g,f,e,d,c,b,a}, 0 = lit
  always_comb begin
    seg_next = 7'b0111111;
    case (cur_digit)
      6'd0:    seg_next = 7'b1000000;
      6'd1:    seg_next = 7'b1111001;
      6'd2:    seg_next = 7'b0100100;
      6'd3:    seg_next = 7'b0110000;
      6'd4:    seg_next = 7'b0011001;
      6'd5:    seg_next = 7'b0010010;
      6'd6:    seg_next = 7'b0000010;
      6'd7:    seg_next = 7'b1111000;
      6'd8:    seg_next = 7'b0000000;
      6'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b0111111;
    endcase
  end

  always_comb begin
    an_next = blank ? 8'hFF : ~(8'h01 << idx);
  end

`ifdef SEVSEG_DP_SEPARATOR_EN
  localparam int BLINK_DIV = CLK_HZ / 2;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt        <= BLINK_LOAD;
      blink_phase <= 1'b0;
    end else if (bcnt == '0) begin
      bcnt        <= BLINK_LOAD;
      blink_phase <= ~blink_phase;
    end else begin
      bcnt <= bcnt - 1'b1;
    end
  end

  // Separators sit after the minutes and hours digits
  always_comb begin
    dp_next = ~(((idx == 3'd2) || (idx == 3'd4)) && !blink_phase);
  end
`else
  always_comb begin
    dp_next = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Display-side consumer of the six BCD digit outputs produced by the time-of-day clock (hours/minutes/seconds, tens and ones). It time-multiplexes those digits onto the Artix-7 board's active-low eight-digit seven-segment display: one digit at a time, at a programmable refresh rate. Digits are snapshotted once per scan frame so a frame never mixes two different clock values.

## Interface
Parameters:
- CLK_HZ, 100000000: system clock frequency; sets the separator blink period.
- REFRESH_DIV, 100000: clk cycles each digit stays lit; must be ≥ 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- blank  in  1  1 = all anodes off; scanning continues
- hrstens, hrsones, mintens, minones, sectens, secones  in  6 each  digit values from the clock; 0–9 valid
- an  out  8  anode enables, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

One clock; reset is synchronous and active-high.

## Operation
- Refresh counter `rcnt` counts 0..REFRESH_DIV-1, then wraps to 0. At the wrap (terminal count), digit index `idx` advances 0→1→2→3→4→5→0.
- Index map: 0 secones, 1 sectens, 2 minones, 3 mintens, 4 hrsones, 5 hrstens. Index k drives an = ~(8'b1 << k). an[7:6] are always 1.
- Shadow registers hold all six digits.
  - Loaded with the live inputs on the cycle where rcnt is at terminal count and idx = 5 (frame wrap).
  - Otherwise they hold their value. Input changes mid-frame therefore never reach the display until the next frame.
- Segment decode of the shadowed digit:
  - 0–9: standard patterns. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - 10–63: dash, seg = 7'b0111111.
- blank = 1: an = 8'hFF on the next edge; seg and dp keep decoding. rcnt, idx and shadow loads are unaffected.
- Reset values:
  - rcnt = 0, idx = 0, shadow digits = 0, blink phase = 0.
  - an = 8'hFF, seg = 7'h7F, dp = 1.

## Timing
- an, seg and dp are registered. They reflect the idx and shadow values of the previous cycle, giving 1-cycle latency from an idx change to a pin change.
- First edge with reset low: outputs show idx 0 with shadow 0, i.e. an = 8'hFE, seg = 7'b1000000.
- idx advances every REFRESH_DIV cycles, so a full frame is 6·REFRESH_DIV cycles.
- A shadow load at a frame wrap takes effect together with idx = 0. The new secones value appears on the pins one cycle after the wrap edge.
- Reset asserted mid-scan: on that edge all state returns to reset values, and outputs go dark in the same cycle.
- blank toggling has 1-cycle latency and does not disturb the scan phase.

## Configuration
- SEVSEG_DP_SEPARATOR_EN defined:
  - A blink counter toggles blink phase every CLK_HZ/2 cycles, giving a 1 Hz period.
  - dp = 0 (lit) when idx ∈ {2, 4} and blink phase = 0. Otherwise dp = 1.
  - The result is blinking hh.mm.ss separators.
- Not defined: no blink counter is built, and dp is tied to 1.

## Test plan
- Reset release, REFRESH_DIV=4: reset high 3 cycles, then low with all inputs 0.
  - Expect first edge an=8'hFE, seg=7'h40.
  - an steps FE→FD→FB→F7→EF→DF→FE, 4 cycles per step.
- Snapshot: drive 23:59:55 at start; mid-frame (idx=2) change secones to 6.
  - Expect the current frame to keep showing 5 at idx 0.
  - Expect the next frame to show seg=7'b0000010 (6) at idx 0.
- Out-of-range: hrstens=12.
  - Expect idx 5 seg=7'b0111111 (dash).
  - Other digits decode normally.
- Blank: assert blank for 10 cycles mid-frame.
  - Expect an=8'hFF during that window.
  - After release, idx continues on the same phase as an unblanked reference run.
- Reset mid-operation: assert reset while idx=3.
  - Expect an=8'hFF, seg=7'h7F, dp=1 on that edge.
  - After release, the scan restarts at idx 0 with a 0 display.
- With SEVSEG_DP_SEPARATOR_EN, CLK_HZ=16, REFRESH_DIV=2:
  - Expect dp=0 only at idx 2 and 4 for 8 cycles, then dp=1 for 8 cycles, repeating.
  - Without the macro, dp=1 always.
